wb_trace_display_queue: RTL
===========================

// Module: wb_trace_display_queue
// PURPOSE
//  Sits downstream of the 5-stage pipeline top level and consumes its writeback
//  stream: the PC and Mux_Mem2Reg_Out value of every register-file write.
//  Buffers these {PC, data} pairs in a FIFO and presents them one at a time to
//  the board display logic. Each entry is held for a fixed dwell time.
//  Overruns are counted rather than stalling the pipeline.
// PARAMETERS
//  DEPTH        16  FIFO entries; power of 2, >= 2
//  HOLD_CYCLES  4   cycles each entry stays on the display; >= 1 (board build uses 50_000_000)
//  DROP_W       8   width of saturating dropped-entry counter
// PORTS
//  Clk        in   1          sole clock; all state updates on rising edge
//  Reset      in   1          synchronous, active-high; clears all state
//  WbValid    in   1          push strobe, wired to pipeline MEM/WB RegWrite
//  WbPC       in   32         PC associated with the writeback
//  WbData     in   32         writeback value (Mux_Mem2Reg_Out)
//  Freeze     in   1          holds the current display entry; dwell counter stops
//  DispValid  out  1          DispPC/DispData hold a live entry
//  DispPC     out  32         PC of the head entry (0 when !DispValid)
//  DispData   out  32         data of the head entry (0 when !DispValid)
//  Count      out  log2(DEPTH)+1  entries currently stored, head included
//  Full       out  1          Count == DEPTH
//  Empty      out  1          Count == 0
//  Overflow   out  1          sticky; set on any dropped push, cleared only by Reset
//  DropCount  out  DROP_W     dropped pushes, saturates at all-ones
// BEHAVIOUR
//  Reset (sync, high):
//   - rd/wr pointers = 0, Count = 0, state = IDLE, HoldCnt = 0.
//   - Overflow = 0, DropCount = 0, DispValid = 0, DispPC = DispData = 0.
//   - Storage array contents are don't-care.
//   - Reset dominates WbValid and Freeze on the same edge; the push is lost and NOT counted as a drop.
//  Storage:
//   - Circular buffer; wr_ptr and rd_ptr each wrap modulo DEPTH.
//   - Count is a separate register, so full and empty are never ambiguous.
//  Push: on an edge with WbValid = 1:
//   - If Count < DEPTH, or a pop occurs on the same edge, write {WbPC, WbData} at wr_ptr and advance wr_ptr.
//   - Otherwise drop the entry: Overflow <= 1 and DropCount += 1 (saturating).
//  Pop: only in SHOW, on an edge where HoldCnt == HOLD_CYCLES-1 and Freeze = 0.
//   - rd_ptr advances and HoldCnt <= 0.
//  Count update:
//   - Count += push_ok - pop. Simultaneous push and pop leaves Count unchanged.
//  FSM (2 states):
//   - IDLE: DispValid = 0. Go to SHOW when Count != 0 at the edge, HoldCnt <= 0.
//     A push into an empty queue therefore shows on DispValid the cycle after the write edge.
//   - SHOW: DispValid = 1; DispPC/DispData = entry at rd_ptr (combinational read of registered state).
//     HoldCnt increments each edge while Freeze = 0. HoldCnt is held while Freeze = 1.
//     On a pop, stay in SHOW if post-pop Count != 0 (next entry shown immediately, no gap cycle).
//     Otherwise go to IDLE.
//  Dwell: with Freeze low, each entry is visible for exactly HOLD_CYCLES cycles.
//   Freeze extends the dwell by the number of frozen cycles.
//  HOLD_CYCLES = 1: pop on every unfrozen SHOW edge.
//  Freeze has no effect on pushes; the queue still fills and may overflow while frozen.
//  Full = (Count == DEPTH); Empty = (Count == 0). Both derive from the registered Count.
// TESTING
//  T1 reset:
//   - Drive WbValid = 1 with Reset = 1 for 3 cycles.
//   - After release expect Count = 0, DispValid = 0, Overflow = 0, DropCount = 0.
//  T2 single entry (HOLD = 4):
//   - One push of PC = 0x0000_0010, data = 0x0000_00AB.
//   - DispValid rises 1 cycle later and stays high exactly 4 cycles showing 0x10 / 0xAB.
//   - Then DispValid = 0 and Empty = 1.
//  T3 back-to-back (DEPTH = 4, HOLD = 4):
//   - Push 0x11, 0x22, 0x33 on consecutive cycles.
//   - Display shows each value 4 cycles with no gap, then IDLE; Count peaks at 3.
//  T4 overflow (DEPTH = 4, HOLD = 1000):
//   - Push 6 entries on consecutive cycles; the first (0x1) is on display, the rest queue.
//   - Expect Full = 1, 2 pushes dropped, Overflow = 1, DropCount = 2.
//   - Stored entries are the first 4 pushed, displayed in order.
//  T5 push+pop when full (DEPTH = 4):
//   - Push at the edge where Count = 4 and the head pops.
//   - Expect the entry accepted, Count stays 4, DropCount unchanged.
//  T6 freeze and wrap:
//   - Freeze for 10 cycles mid-dwell: the entry shows 4+10 cycles.
//   - Run 40 push/pop pairs (DEPTH = 4): pointers wrap and data order is preserved.
//   - Saturation check: force 300 drops with DROP_W = 8; DropCount holds 255.

Source files
------------

// File: rtl/wb_trace_display_queue.sv
// Buffers {PC, data} pairs from the pipeline writeback stream and shows each one
// on the board display for a fixed dwell time; overruns are counted, never stalled.
module wb_trace_display_queue #(
    parameter int DEPTH       = 16,
    parameter int HOLD_CYCLES = 4,
    parameter int DROP_W      = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     WbValid,
    input  logic [31:0]              WbPC,
    input  logic [31:0]              WbData,
    input  logic                     Freeze,
    output logic                     DispValid,
    output logic [31:0]              DispPC,
    output logic [31:0]              DispData,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Full,
    output logic                     Empty,
    output logic                     Overflow,
    output logic [DROP_W-1:0]        DropCount
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t              state, state_nxt;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count, count_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic                overflow;
    logic [DROP_W-1:0]   drop_cnt;
    logic [63:0]         mem [DEPTH];
    logic [63:0]         head;
    logic                pop, push_ok, push_drop;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    // A pop frees a slot on the same edge, so a push into a full queue still lands.
    assign pop       = (state == SHOW) && !Freeze && (hold_cnt == HOLD_LAST);
    assign push_ok   = WbValid && ((count < DEPTH_C) || pop);
    assign push_drop = WbValid && !push_ok;

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                hold_nxt = '0;
                if (count != '0)
                    state_nxt = SHOW;
            end
            SHOW: begin
                if (pop) begin
                    hold_nxt = '0;
                    if (count_nxt == '0)
                        state_nxt = IDLE;
                end else if (!Freeze) begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            hold_cnt <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            count    <= count_nxt;
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_drop) begin
                overflow <= 1'b1;
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    // Storage holds data only; its contents are meaningless until written.
    always_ff @(posedge Clk) begin
        if (push_ok)
            mem[wr_ptr] <= {WbPC, WbData};
    end

    assign head      = mem[rd_ptr];
    assign DispValid = (state == SHOW);
    assign DispPC    = DispValid ? head[63:32] : 32'h0;
    assign DispData  = DispValid ? head[31:0]  : 32'h0;
    assign Count     = count;
    assign Full      = (count == DEPTH_C);
    assign Empty     = (count == '0);
    assign Overflow  = overflow;
    assign DropCount = drop_cnt;

endmodule
